// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the memory-wait FSM states, forward-select codes and a register-match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        HALT
    } hzState_e;

    localparam logic [1:0] FWD_ID    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Producer writes a real register that the consumer actually reads.
    function automatic logic regMatch(
        input logic [4:0] rd,
        input logic       regWrite,
        input logic [4:0] rs,
        input logic       useRs
    );
        return regWrite && (rd != 5'd0) && useRs && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// EX operand forwarding selects from EX/MEM and MEM/WB producers.
// Ports: rs1/rs2 + use bits of the consumer, memRd/wbRd + RegWrite, forwardA/forwardB selects.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       useRs1,
    input  logic       useRs2,
    input  logic [4:0] memRd,
    input  logic       memRegWrite,
    input  logic [4:0] wbRd,
    input  logic       wbRegWrite,
    output logic [1:0] forwardA,
    output logic [1:0] forwardB
);

    logic memA;
    logic memB;
    logic wbA;
    logic wbB;

    assign memA = regMatch(memRd, memRegWrite, rs1, useRs1);
    assign memB = regMatch(memRd, memRegWrite, rs2, useRs2);
    assign wbA  = regMatch(wbRd, wbRegWrite, rs1, useRs1);
    assign wbB  = regMatch(wbRd, wbRegWrite, rs2, useRs2);

    // The younger EX/MEM result wins over MEM/WB.
    assign forwardA = memA ? FWD_EXMEM : (wbA ? FWD_MEMWB : FWD_ID);
    assign forwardB = memB ? FWD_EXMEM : (wbB ? FWD_MEMWB : FWD_ID);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: pipeline enables, flushes, forwarding, dmem timeout halt, stall counter.
// Ports: ID sources, EX/MEM/WB dests, branch/dmem status in; enables, flushes, forward_a/b, halted,
// stall_cnt out. Optional macro HAZARD_FORWARDING_EN enables forwarding (else stall on EX/MEM RAW).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             ex_regwrite,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    hzState_e         state;
    logic [WCW-1:0]   waitCnt;
    logic [WCW-1:0]   waitNext;
    logic [CNT_W-1:0] stallCnt;
    logic             memMiss;
    logic             freeze;
    logic             exMatch;
    logic             loadUse;

    assign exMatch = regMatch(ex_rd, ex_regwrite, id_rs1, id_use_rs1)
                   | regMatch(ex_rd, ex_regwrite, id_rs2, id_use_rs2);

`ifdef HAZARD_FORWARDING_EN
    // Only a load result is too late to forward into the next EX.
    assign loadUse = ex_memread & exMatch;

    hazard_fwd_unit uFwd (
        .rs1         (id_rs1),
        .rs2         (id_rs2),
        .useRs1      (id_use_rs1),
        .useRs2      (id_use_rs2),
        .memRd       (mem_rd),
        .memRegWrite (mem_regwrite),
        .wbRd        (wb_rd),
        .wbRegWrite  (wb_regwrite),
        .forwardA    (forward_a),
        .forwardB    (forward_b)
    );
`else
    logic unusedIn;

    // WB is covered by the write-before-read register file.
    assign loadUse = exMatch
                   | regMatch(mem_rd, mem_regwrite, id_rs1, id_use_rs1)
                   | regMatch(mem_rd, mem_regwrite, id_rs2, id_use_rs2);
    assign forward_a = FWD_ID;
    assign forward_b = FWD_ID;
    assign unusedIn  = ^{ex_memread, wb_rd, wb_regwrite};
`endif

    assign memMiss  = dmem_req & ~dmem_ready;
    assign freeze   = memMiss | (state == HALT);
    assign waitNext = waitCnt + 1'b1;

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        unique case (1'b1)
            freeze: begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_we     = 1'b0;
                memwb_bubble = 1'b1;
            end
            (!freeze && ex_branch_taken): begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            (!freeze && !ex_branch_taken && loadUse): begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            waitCnt  <= '0;
            stallCnt <= '0;
            halted   <= 1'b0;
        end else begin
            if (!pc_we && stallCnt != '1) begin
                stallCnt <= stallCnt + 1'b1;
            end
            unique case (state)
                RUN: begin
                    if (memMiss) begin
                        waitCnt <= waitNext;
                        if (waitNext == WCW'(MEM_TIMEOUT)) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitNext;
                        if (waitNext == WCW'(MEM_TIMEOUT)) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT: ;
                default: state <= RUN;
            endcase
        end
    end

    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus.
// Expected values come from a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int  T    = 16;
    localparam int  CW   = 16;
    localparam longint SMAX = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          ex_regwrite, mem_regwrite, wb_regwrite;
    logic          ex_memread, ex_branch_taken, dmem_req, dmem_ready;
    logic          pc_we, ifid_we, idex_we, exmem_we;
    logic          ifid_flush, idex_flush, memwb_bubble;
    logic [1:0]    forward_a, forward_b;
    logic          halted;
    logic [CW-1:0] stall_cnt;

    int     nCmp = 0;
    int     nBad = 0;
    bit     mHalt, mWait;
    int     mCnt;
    longint mStall;
    bit     expPc;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
        .exmem_we(exmem_we), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .forward_a(forward_a), .forward_b(forward_b),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input int rd, input bit rw,
                               input int rs, input bit u);
        return rw && rd != 0 && u && rs == rd;
    endfunction

    task automatic clearIn();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0;
        ex_memread = 0; ex_branch_taken = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic checkAll(input string tag);
        bit frz, lu, e1, e2, m1, m2, w1, w2;
        logic [6:0] ev;
        int fa, fb;
        frz = (dmem_req && !dmem_ready) || mHalt;
        e1 = hit(ex_rd, ex_regwrite, id_rs1, id_use_rs1);
        e2 = hit(ex_rd, ex_regwrite, id_rs2, id_use_rs2);
        m1 = hit(mem_rd, mem_regwrite, id_rs1, id_use_rs1);
        m2 = hit(mem_rd, mem_regwrite, id_rs2, id_use_rs2);
        w1 = hit(wb_rd, wb_regwrite, id_rs1, id_use_rs1);
        w2 = hit(wb_rd, wb_regwrite, id_rs2, id_use_rs2);
`ifdef HAZARD_FORWARDING_EN
        lu = ex_memread && (e1 || e2);
        fa = m1 ? 2 : (w1 ? 1 : 0);
        fb = m2 ? 2 : (w2 ? 1 : 0);
`else
        lu = e1 || e2 || m1 || m2;
        fa = 0;
        fb = 0;
        if (w1 || w2) lu = lu;
`endif
        // order: pc ifid idex exmem ifidFl idexFl bubble
        if (frz)                  ev = 7'b0000001;
        else if (ex_branch_taken) ev = 7'b1111110;
        else if (lu)              ev = 7'b0011010;
        else                      ev = 7'b1111000;
        expPc = ev[6];
        chk({tag, ".ctl"}, {25'd0, pc_we, ifid_we, idex_we, exmem_we,
            ifid_flush, idex_flush, memwb_bubble}, {25'd0, ev});
        chk({tag, ".fwdA"}, {30'd0, forward_a}, fa);
        chk({tag, ".fwdB"}, {30'd0, forward_b}, fb);
        chk({tag, ".halt"}, {31'd0, halted}, {31'd0, mHalt});
        chk({tag, ".scnt"}, {16'd0, stall_cnt}, mStall[31:0]);
    endtask

    task automatic modelEdge();
        bit miss;
        miss = dmem_req && !dmem_ready;
        if (!expPc && mStall < SMAX) mStall++;
        if (!mHalt) begin
            if (mWait) begin
                if (dmem_ready) begin
                    mWait = 0;
                    mCnt = 0;
                end else begin
                    mCnt++;
                    if (mCnt >= T) begin mHalt = 1; mWait = 0; end
                end
            end else if (miss) begin
                mCnt = 1;
                if (mCnt >= T) mHalt = 1;
                else mWait = 1;
            end
        end
    endtask

    task automatic cycle(input string tag);
        #1;
        checkAll(tag);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        mHalt = 0; mWait = 0; mCnt = 0; mStall = 0;
        chk("rst.halt", {31'd0, halted}, 0);
        chk("rst.scnt", {16'd0, stall_cnt}, 0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clearIn();
        doReset();
        cycle("idle");

        // load-use: lw x5 in EX, ID reads x5
        doReset();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5;
        id_rs1 = 5; id_use_rs1 = 1;
        cycle("lu");
        clearIn();
        chk("lu.cnt", {16'd0, stall_cnt}, 1);
        cycle("luAfter");

        // forwarding: EX/MEM beats MEM/WB, rd=0 never matches
        mem_rd = 3; wb_rd = 3; mem_regwrite = 1; wb_regwrite = 1;
        id_rs2 = 3; id_use_rs2 = 1;
        cycle("fwd3");
        mem_rd = 0; wb_rd = 0;
        cycle("fwd0");
        mem_rd = 0; wb_rd = 3;
        cycle("fwdWb");
        clearIn();

        // branch beats load-use; freeze defers branch
        ex_branch_taken = 1; ex_memread = 1; ex_regwrite = 1;
        ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        cycle("brLu");
        dmem_req = 1; dmem_ready = 0;
        cycle("brFrz1");
        chk("brFrz.flush", {31'd0, ifid_flush}, 0);
        cycle("brFrz2");
        dmem_ready = 1;
        #1;
        chk("brGo.flush", {31'd0, ifid_flush}, 1);
        cycle("brGo");
        clearIn();

        // memory wait 3 cycles
        doReset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) cycle("wait");
        chk("wait.cnt", {16'd0, stall_cnt}, 3);
        dmem_ready = 1;
        cycle("waitDone");
        clearIn();
        cycle("waitRun");

        // no forwarding path: EX, MEM stall, WB does not (both modes via model)
        ex_regwrite = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        cycle("nfEx");
        ex_regwrite = 0; mem_regwrite = 1; mem_rd = 7;
        cycle("nfMem");
        mem_regwrite = 0; wb_regwrite = 1; wb_rd = 7;
        cycle("nfWb");
        clearIn();

        // timeout
        doReset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < T; i++) cycle("to");
        chk("to.halt", {31'd0, halted}, 1);
        clearIn();
        cycle("toHeld1");
        cycle("toHeld2");
        chk("to.frozen", {31'd0, pc_we}, 0);
        doReset();
        cycle("toReset");

        // random
        for (int n = 0; n < 600; n++) begin
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_regwrite  = 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite  = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            dmem_req   = ($urandom_range(0, 2) != 0);
            dmem_ready = ($urandom_range(0, 4) < 2);
            if ($urandom_range(0, 99) == 0) doReset();
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
